// File: rtl/bos_pkg.sv
// Shared constants for the slave-bus reply path.
package bos_pkg;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned MAX_MSG_LEN = 255;
endpackage

// File: rtl/sync_fifo_sa.sv
// Small show-ahead synchronous FIFO: data_o always shows the head entry.
module sync_fifo_sa #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/reply_buffer.sv
// Reply message buffer: stores only complete messages, drops overflowing ones whole.
// Optional saturating drop counter enabled by REPLY_BUF_DROP_CNT_EN.
module reply_buffer
    import bos_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LEN_DEPTH = 8
) (
    input  logic              n_rst,
    input  logic              clk,
    input  logic              wr_ena,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              flush,
    input  logic              rdreq,
    output logic              have_msg,
    output logic [LEN_W-1:0]  len,
    output logic [BYTE_W-1:0] out_data,
    output logic              overflow
`ifdef REPLY_BUF_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_spec_q, wr_spec_d;
    logic [AW:0]       wr_com_q, wr_com_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  msg_cnt_q, msg_cnt_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              bad_q, bad_d;
    logic              ovf_q, ovf_d;

    logic              store_full, byte_bad, byte_wr, commit, commit_ok;
    logic              rd_fire, last_pop;
    logic [LEN_W-1:0]  len_head;
    logic              len_empty, len_full;

    // Occupancy counts speculative bytes against the read pointer, not the committed one.
    assign store_full = ((wr_spec_q - rd_ptr_q) == (AW+1)'(DEPTH));
    assign byte_bad   = bad_q | store_full | (msg_cnt_q == LEN_W'(MAX_MSG_LEN));
    assign byte_wr    = wr_ena & ~flush & ~byte_bad;
    assign commit     = wr_ena & wr_last & ~flush;
    assign commit_ok  = commit & ~byte_bad & ~len_full;

    assign have_msg = ~len_empty;
    assign rd_fire  = rdreq & have_msg & ~flush;
    assign last_pop = rd_fire & ((rd_cnt_q + 1'b1) == len_head);
    assign len      = have_msg ? len_head : '0;
    assign out_data = have_msg ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign overflow = ovf_q;

    always_comb begin
        wr_spec_d = wr_spec_q;
        wr_com_d  = wr_com_q;
        rd_ptr_d  = rd_ptr_q;
        msg_cnt_d = msg_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        bad_d     = bad_q;
        ovf_d     = 1'b0;
        if (flush) begin
            wr_spec_d = '0;
            wr_com_d  = '0;
            rd_ptr_d  = '0;
            msg_cnt_d = '0;
            rd_cnt_d  = '0;
            bad_d     = 1'b0;
        end else begin
            if (wr_ena) begin
                if (wr_last) begin
                    if (commit_ok) begin
                        wr_spec_d = wr_spec_q + 1'b1;
                        wr_com_d  = wr_spec_q + 1'b1;
                    end else begin
                        wr_spec_d = wr_com_q;
                        ovf_d     = 1'b1;
                    end
                    msg_cnt_d = '0;
                    bad_d     = 1'b0;
                end else if (byte_bad) begin
                    bad_d = 1'b1;
                end else begin
                    wr_spec_d = wr_spec_q + 1'b1;
                    msg_cnt_d = msg_cnt_q + 1'b1;
                end
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rd_cnt_d = last_pop ? '0 : rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_spec_q <= '0;
            wr_com_q  <= '0;
            rd_ptr_q  <= '0;
            msg_cnt_q <= '0;
            rd_cnt_q  <= '0;
            bad_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_spec_q <= wr_spec_d;
            wr_com_q  <= wr_com_d;
            rd_ptr_q  <= rd_ptr_d;
            msg_cnt_q <= msg_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            bad_q     <= bad_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_wr) mem_q[wr_spec_q[AW-1:0]] <= wr_data;
    end

    sync_fifo_sa #(
        .WIDTH (LEN_W),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk_i   (clk),
        .rst_ni  (n_rst),
        .clr_i   (flush),
        .push_i  (commit_ok),
        .data_i  (msg_cnt_q + 1'b1),
        .pop_i   (last_pop),
        .data_o  (len_head),
        .empty_o (len_empty),
        .full_o  (len_full)
    );

`ifdef REPLY_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_cnt_q <= '0;
        end else if (ovf_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_reply_buffer.sv
// Scoreboard bench for reply_buffer: message-level reference model plus negedge monitor.
module tb_reply_buffer;
    localparam int DEPTH     = 256;
    localparam int LEN_DEPTH = 8;
    localparam int MAXLEN    = 255;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       wr_ena = 1'b0, wr_last = 1'b0, flush = 1'b0, rdreq = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       have_msg, overflow;
    logic [7:0] len, out_data;
`ifdef REPLY_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    reply_buffer #(
        .DEPTH     (DEPTH),
        .LEN_DEPTH (LEN_DEPTH)
    ) dut (
        .n_rst    (n_rst),
        .clk      (clk),
        .wr_ena   (wr_ena),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .flush    (flush),
        .rdreq    (rdreq),
        .have_msg (have_msg),
        .len      (len),
        .out_data (out_data),
        .overflow (overflow)
`ifdef REPLY_BUF_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] d;
    } sb_t;

    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    // Reference model: queued message lengths, unread byte total, in-progress message.
    int         q_len[$];
    int         head_rd = 0;
    int         occ = 0;
    logic [7:0] cur_bytes[$];
    bit         cur_bad = 1'b0;
    bit         exp_ovf = 1'b0;
    int         exp_drops = 0;
    sb_t        sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit we, input logic [7:0] wd, input bit wl, input bit rr,
                         input bit fl);
        bit pop;
        bit bad;
        exp_ovf = 1'b0;
        if (fl) begin
            q_len.delete();
            cur_bytes.delete();
            sb.delete();
            head_rd = 0;
            occ     = 0;
            cur_bad = 1'b0;
            return;
        end
        pop = rr && (q_len.size() > 0);
        if (we) begin
            bad = cur_bad || (occ + cur_bytes.size() >= DEPTH) || (cur_bytes.size() >= MAXLEN);
            if (!bad) cur_bytes.push_back(wd);
            if (wl) begin
                if (!bad && q_len.size() < LEN_DEPTH) begin
                    q_len.push_back(cur_bytes.size());
                    occ += cur_bytes.size();
                    foreach (cur_bytes[k]) sb.push_back({8'(cur_bytes.size()), cur_bytes[k]});
                end else begin
                    exp_ovf = 1'b1;
                    if (exp_drops < 255) exp_drops++;
                end
                cur_bytes.delete();
                cur_bad = 1'b0;
            end else if (bad) begin
                cur_bad = 1'b1;
            end
        end
        if (pop) begin
            occ--;
            head_rd++;
            if (head_rd == q_len[0]) begin
                void'(q_len.pop_front());
                head_rd = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("have_msg", have_msg, q_len.size() > 0);
            check("overflow", overflow, exp_ovf);
`ifdef REPLY_BUF_DROP_CNT_EN
            check("drop_cnt", drop_cnt, exp_drops);
`endif
            if (have_msg) begin
                if (sb.size() == 0) begin
                    check("sb_underrun", 1, 0);
                end else begin
                    check("out_data", out_data, sb[0].d);
                    check("len", len, sb[0].l);
                    if (rdreq) void'(sb.pop_front());
                end
            end else begin
                check("len_idle", len, 0);
                check("out_idle", out_data, 0);
            end
        end
    end

    task automatic step(input bit we, input logic [7:0] wd, input bit wl, input bit rr,
                        input bit fl);
        wr_ena  = we;
        wr_data = wd;
        wr_last = wl;
        rdreq   = rr;
        flush   = fl;
        @(posedge clk);
        model(we, wd, wl, rr, fl);
        #1;
    endtask

    task automatic send_msg(input int n, input logic [7:0] base, input bit rr);
        for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), i == n - 1, rr, 1'b0);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rr, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (q_len.size() == 0 && !have_msg) break;
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check("drain_bound", have_msg, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_have_msg", have_msg, 0);
        check("rst_len", len, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overflow", overflow, 0);
`ifdef REPLY_BUF_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic 3-byte message, then three pops.
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        idle(2, 1'b0);

        // Back-to-back messages with continuous reading.
        send_msg(2, 8'h10, 1'b1);
        send_msg(1, 8'h20, 1'b1);
        idle(4, 1'b1);

        // Store overflow, then over-length and max-length messages.
        send_msg(200, 8'h00, 1'b0);
        send_msg(100, 8'h80, 1'b0);
        drain();
        send_msg(256, 8'h40, 1'b0);
        send_msg(255, 8'hC0, 1'b0);
        drain();

        // Length FIFO overflow.
        for (int i = 0; i < LEN_DEPTH + 1; i++) send_msg(1, 8'(8'h70 + i), 1'b0);
        drain();

        // Commit on the same edge as the final pop of the head message.
        send_msg(2, 8'h30, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
        drain();

        // Flush with a queued message and a partial one in flight.
        send_msg(3, 8'h50, 1'b0);
        step(1'b1, 8'h58, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h59, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        send_msg(2, 8'h60, 1'b0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit we, wl, rr, fl;
            we = ($urandom_range(0, 3) != 0);
            wl = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
            rr = ((i % 1000) < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 499) == 0);
            step(we, 8'($urandom), wl, rr, fl);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        drain();
        idle(1, 1'b0);
        check("sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
